z16_imem_loader: RTL
====================

# z16_imem_loader

Controller that owns the single port of the Z16 writable instruction memory and shares it between CPU instruction fetch and a byte-serial program loader. In normal operation it passes fetch addresses through to the memory. On a load request it freezes the CPU, assembles little-endian byte pairs into 16-bit words and writes them to consecutive word addresses from 0, then releases the CPU. It sits between the Z16 core's fetch stage and the instruction memory array.

## Interface
- ADDR_W, 4, instruction memory word-address width (depth 2^ADDR_W words)
- i_clk  in  1  clock; all state changes on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_fetch_addr  in  16  CPU byte address of instruction; word index = i_fetch_addr[ADDR_W:1]
- o_fetch_instr  out  16  instruction to CPU
- o_cpu_hold  out  1  CPU must not advance PC while high
- i_ld_start  in  1  load request, single-cycle sample
- i_ld_len  in  ADDR_W+1  number of words to load
- i_ld_abort  in  1  cancel load in progress
- i_ld_byte  in  8  loader data byte
- i_ld_valid  in  1  i_ld_byte valid
- o_ld_ready  out  1  loader byte accepted when valid && ready
- o_done  out  1  one-cycle pulse at end of load (normal or aborted)
- o_mem_addr  out  ADDR_W  memory word address
- o_mem_wdata  out  16  memory write data
- o_mem_we  out  1  memory write enable, write occurs at rising edge
- i_mem_rdata  in  16  memory combinational read data at o_mem_addr

## Operation
- States: RUN, LO, HI, WR, REL. Registers: state, word count cnt (ADDR_W+1 bits), latched length len, low byte lo, high byte hi.
- RUN: o_mem_addr = i_fetch_addr[ADDR_W:1]; o_fetch_instr = i_mem_rdata; o_cpu_hold=0; o_ld_ready=0; o_mem_we=0.
- RUN, i_ld_start=1 and i_ld_len!=0: len <= min(i_ld_len, 2^ADDR_W); cnt <= 0; -> LO. i_ld_len==0: start ignored, stay RUN, no o_done.
- LO: o_ld_ready=1; on i_ld_valid: lo <= i_ld_byte, -> HI.
- HI: o_ld_ready=1; on i_ld_valid: hi <= i_ld_byte, -> WR.
- WR: o_ld_ready=0; o_mem_we=1; o_mem_addr=cnt[ADDR_W-1:0]; o_mem_wdata={hi,lo}; cnt <= cnt+1; if cnt+1==len -> REL else -> LO.
- REL: o_done=1 for this single cycle; -> RUN.
- In LO, HI, WR, REL: o_cpu_hold=1 and o_fetch_instr=16'h0000 (ADD ZR ZR ZR, a NOP), regardless of i_mem_rdata.
- o_mem_we is 1 only in WR. o_mem_addr in LO/HI/REL = cnt[ADDR_W-1:0]; o_mem_wdata outside WR = {hi,lo} (don't-care to memory).
- i_ld_abort in LO or HI: -> REL immediately, partial word discarded, no write. Abort in WR: the write completes, then -> REL. Abort in RUN/REL: ignored. Abort has priority over i_ld_valid in the same cycle; that byte is not consumed.
- i_ld_start while not in RUN: ignored.
- i_rst (any state, including mid-load): state RUN, cnt=0, len=0, lo=hi=0. Words already written remain in memory; no o_done.

## Timing
- Reset values: o_cpu_hold=0, o_ld_ready=0, o_mem_we=0, o_done=0, o_fetch_instr=i_mem_rdata (pass-through), o_mem_addr=i_fetch_addr[ADDR_W:1].
- Fetch path in RUN is purely combinational, zero latency.
- Start sampled at edge t: o_cpu_hold and o_ld_ready high from cycle t+1.
- Per word minimum 3 cycles (LO, HI, WR); each cycle without valid in LO/HI adds one.
- With i_ld_valid held high, an N-word load has o_done high in cycle t+3N+1; o_cpu_hold low from cycle t+3N+2.
- Byte handshake: transfer occurs on a cycle where i_ld_valid && o_ld_ready at the rising edge; loader may not change i_ld_byte while valid && !ready.

## Test plan
- Fetch pass-through: state RUN, i_fetch_addr=0x0006, memory[3]=0x0040 -> o_mem_addr=3, o_fetch_instr=0x0040, o_cpu_hold=0, same cycle.
- Two-word load, continuous valid: start, len=2, bytes 0x10,0x00,0x19,0x01 -> writes mem[0]=0x0010, mem[1]=0x0119; o_done 7 cycles after start; subsequent fetch of 0x0002 returns 0x0119; o_fetch_instr=0x0000 throughout hold.
- Backpressure: same load with 2 idle cycles before each byte -> identical memory contents, o_done delayed by 8 cycles, exactly 2 o_mem_we pulses.
- Abort after low byte of word 1 (len=3): mem[0] written, mem[1]/mem[2] unchanged, o_done one cycle after abort, hold released next cycle.
- Length bounds: len=0 -> no hold, no done; len=20 with ADDR_W=4 -> exactly 16 writes to addresses 0..15, then o_done.
- Reset mid-load during HI of word 2: next cycle o_cpu_hold=0, o_ld_ready=0, no o_done, mem[0..1] retain written values; a new start loads from address 0.

Source files
------------

// File: rtl/z16_imem_loader_if.sv
// Loader handshake and instruction-memory port bundle for z16_imem_loader.
// slave = the controller; master = loader source plus memory array.
interface z16_imem_loader_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              ld_start;
  logic [ADDR_W:0]   ld_len;
  logic              ld_abort;
  logic [7:0]        ld_byte;
  logic              ld_valid;
  logic              ld_ready;
  logic              done;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic [15:0]       mem_rdata;

  modport slave (
    input  ld_start, ld_len, ld_abort, ld_byte, ld_valid, mem_rdata,
    output ld_ready, done, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output ld_start, ld_len, ld_abort, ld_byte, ld_valid, mem_rdata,
    input  ld_ready, done, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/z16_imem_loader.sv
// Shares the Z16 instruction-memory port between CPU fetch and a byte-serial
// program loader; holds the CPU and feeds it NOPs while a load is in progress.
module z16_imem_loader #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [15:0]             i_fetch_addr,
  output logic [15:0]             o_fetch_instr,
  output logic                    o_cpu_hold,
  z16_imem_loader_if.slave        bus
);

  typedef enum logic [2:0] {
    RUN,
    LO,
    HI,
    WR,
    REL
  } state_t;

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [7:0]        lo_q, lo_d;
  logic [7:0]        hi_q, hi_d;

  logic [ADDR_W-1:0] fetch_word;
  logic [ADDR_W:0]   cnt_inc;
  logic              unused_fetch_bits;

  // Fetch addresses are byte addresses; instructions are word aligned.
  assign fetch_word        = i_fetch_addr[ADDR_W:1];
  assign unused_fetch_bits = ^{i_fetch_addr[15:ADDR_W+1], i_fetch_addr[0]};
  assign cnt_inc           = cnt_q + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
      len_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    lo_d          = lo_q;
    hi_d          = hi_q;
    o_fetch_instr = '0;
    o_cpu_hold    = 1'b1;
    bus.ld_ready  = 1'b0;
    bus.done      = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = cnt_q[ADDR_W-1:0];
    bus.mem_wdata = {hi_q, lo_q};

    unique case (state_q)
      RUN: begin
        o_cpu_hold    = 1'b0;
        bus.mem_addr  = fetch_word;
        o_fetch_instr = bus.mem_rdata;
        if (bus.ld_start && (bus.ld_len != '0)) begin
          len_d   = (bus.ld_len > LEN_MAX) ? LEN_MAX : bus.ld_len;
          cnt_d   = '0;
          state_d = LO;
        end
      end

      // Abort outranks a byte offered in the same cycle; that byte stays unconsumed.
      LO: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_abort) begin
          state_d = REL;
        end else if (bus.ld_valid) begin
          lo_d    = bus.ld_byte;
          state_d = HI;
        end
      end

      HI: begin
        bus.ld_ready = 1'b1;
        if (bus.ld_abort) begin
          state_d = REL;
        end else if (bus.ld_valid) begin
          hi_d    = bus.ld_byte;
          state_d = WR;
        end
      end

      WR: begin
        bus.mem_we = 1'b1;
        cnt_d      = cnt_inc;
        if (bus.ld_abort || (cnt_inc == len_q)) begin
          state_d = REL;
        end else begin
          state_d = LO;
        end
      end

      REL: begin
        bus.done = 1'b1;
        state_d  = RUN;
      end

      default: begin
        state_d = RUN;
      end
    endcase
  end

endmodule
